// File: rtl/lsu_pkg.sv
// Shared constants for the data-memory load/store unit: widths, RV32 funct3 codes,
// FSM states and the request legality check.
package lsu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_e;

  // Unknown size code for the access direction, or a misaligned halfword/word.
  function automatic logic lsu_bad_req(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] byte_off);
    logic legal;
    logic misaligned;
    if (we) legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
    else    legal = (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
                    (funct3 == F3_BU) || (funct3 == F3_HU);
    misaligned = ((funct3[1:0] == 2'b01) && byte_off[0]) ||
                 ((funct3[1:0] == 2'b10) && (byte_off != 2'b00));
    return !legal || misaligned;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte/halfword lane handling: load extract with sign/zero extension, and
// read-modify-write merge of store data into the old memory word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        funct3,
  input  logic [1:0]        byte_off,
  input  logic [DATA_W-1:0] rdata,
  input  logic [15:0]       wdata,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merge_data
);

  logic [7:0]         lane_b;
  logic [15:0]        lane_h;
  logic signed [7:0]  lane_b_s;
  logic signed [15:0] lane_h_s;

  always_comb begin
    lane_b   = 8'(rdata >> {byte_off, 3'b000});
    lane_h   = 16'(rdata >> {byte_off[1], 4'b0000});
    lane_b_s = signed'(lane_b);
    lane_h_s = signed'(lane_h);
    case (funct3)
      F3_B:    load_data = DATA_W'(lane_b_s);
      F3_H:    load_data = DATA_W'(lane_h_s);
      F3_BU:   load_data = {24'b0, lane_b};
      F3_HU:   load_data = {16'b0, lane_h};
      default: load_data = rdata;
    endcase
  end

  always_comb begin
    merge_data = rdata;
    if (funct3[1:0] == 2'b00) begin
      case (byte_off)
        2'd0:    merge_data[7:0]   = wdata[7:0];
        2'd1:    merge_data[15:8]  = wdata[7:0];
        2'd2:    merge_data[23:16] = wdata[7:0];
        default: merge_data[31:24] = wdata[7:0];
      endcase
    end else if (byte_off[1]) begin
      merge_data[31:16] = wdata;
    end else begin
      merge_data[15:0] = wdata;
    end
  end

endmodule

// File: rtl/data_mem_lsu.sv
// RV32 load/store unit in front of a word-wide data memory.
// Build option LSU_BOUNDS_CHECK_EN: out-of-range addresses error instead of wrapping.
module data_mem_lsu
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr_en,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'(MEM_BYTES - 1);

  lsu_state_e        state;
  logic              we_p0;
  logic [2:0]        funct3_p0;
  logic [1:0]        off_p0;
  logic [15:0]       wdata_p0;
  logic [ADDR_W-1:0] word_addr;
  logic              req_err;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;

  always_comb begin
    word_addr = {req_addr[ADDR_W-1:2], 2'b00};
    req_err   = lsu_bad_req(req_we, req_funct3, req_addr[1:0]);
`ifdef LSU_BOUNDS_CHECK_EN
    req_err   = req_err || (word_addr >= ADDR_W'(MEM_BYTES));
`else
    word_addr = word_addr & ADDR_MASK;
`endif
  end

  lsu_align u_align (
    .funct3     (funct3_p0),
    .byte_off   (off_p0),
    .rdata      (mem_rdata),
    .wdata      (wdata_p0),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  assign req_ready = (state == ST_IDLE);
  assign rsp_valid = (state == ST_RESP);
  assign mem_wr_en = (state == ST_WRITE);

  // Stage p0: request latched at accept; memory word read/merged in READ.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      we_p0     <= 1'b0;
      funct3_p0 <= '0;
      off_p0    <= '0;
      wdata_p0  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            we_p0     <= req_we;
            funct3_p0 <= req_funct3;
            off_p0    <= req_addr[1:0];
            wdata_p0  <= req_wdata[15:0];
            mem_addr  <= word_addr;
            mem_wdata <= req_wdata;
            rsp_rdata <= '0;
            rsp_err   <= req_err;
            if (req_err)                          state <= ST_RESP;
            else if (req_we && req_funct3 == F3_W) state <= ST_WRITE;
            else                                  state <= ST_READ;
          end
        end
        ST_READ: begin
          if (we_p0) begin
            mem_wdata <= merge_data;
            state     <= ST_WRITE;
          end else begin
            rsp_rdata <= load_data;
            state     <= ST_RESP;
          end
        end
        ST_WRITE: state <= ST_RESP;
        default: begin
          if (rsp_ready) state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
